apb_regfile_slave: RTL and testbench
====================================

# apb_regfile_slave

APB4 completer holding a 16-entry, 32-bit register bank, instantiated once per `psel` line downstream of the APB master/decoder. It adds a programmable number of wait states, byte-strobed writes, privilege checking via `pprot`, and error signalling on `pslverr`. It also provides a saturating error counter and a read-only ID register. The master consumes its `prdata`, `pready` and `pslverr`.

## Interface
- `WAIT_STATES`, default 1: `pready` low cycles inserted in the access phase; legal range 0..15.
- `PRIV_REGS`, default 4: registers 0..PRIV_REGS-1 require privileged writes; legal range 0..14.
- `ID_VALUE`, default 32'hA9B0_0001: constant returned by register 15.
- `pclk`  in  1  clock; all state changes on the rising edge.
- `preset`  in  1  reset, asynchronous, active-high.
- `psel`  in  1  select from the master decoder.
- `penable`  in  1  access-phase indicator.
- `paddr`  in  32  byte address. [31:30] are decoded upstream; [5:2] give the register index.
- `pwrite`  in  1  1 = write, 0 = read.
- `pprot`  in  3  protection; only bit 0 (privileged) is used.
- `pwdata`  in  32  write data.
- `pstrb`  in  4  byte-lane write strobes; ignored on reads.
- `prdata`  out  32  read data; valid only in the completion cycle, 0 otherwise.
- `pslverr`  out  1  error response; valid only in the completion cycle, 0 otherwise.
- `pready`  out  1  transfer-complete indicator.

## Operation
- Register map (index = `paddr[5:2]`):
  - 0..13: general read/write.
  - 14: ERRCNT. Bits [7:0] hold the count, [31:8] read 0. Any accepted write clears it, regardless of data or strobes.
  - 15: ID. Read-only, returns `ID_VALUE`.
- FSM states: IDLE and ACCESS. The wait counter `wcnt` is 4 bits.
  - IDLE: when `psel`=1 and `penable`=0 (setup cycle), capture `paddr`, `pwrite`, `pwdata`, `pstrb` and `pprot[0]`. Load `wcnt`=`WAIT_STATES` and go to ACCESS.
  - ACCESS, with `psel`=1 and `penable`=1:
    - If `wcnt`≠0, decrement it.
    - If `wcnt`=0, this is the completion cycle: `pready`=1. Commit the write at the closing edge, then go to IDLE.
  - ACCESS with `psel`=0: protocol abort. Return to IDLE, no write, no error counted.
- Error conditions, evaluated on the captured values; any one sets `pslverr`=1 in the completion cycle:
  - `paddr[1:0]`≠0 (misaligned).
  - `paddr[29:6]`≠0 (out of range).
  - Write to index 15.
  - Write to an index below `PRIV_REGS` with `pprot[0]`=0.
- An errored write modifies nothing. An errored read returns `prdata`=0.
- Writes: for each lane i, byte i is updated only if `pstrb[i]`=1. `pstrb`=0 on a write is legal: no change, no error.
- Reads: `prdata` = the selected register during the completion cycle only.
- ERRCNT increments by 1 at every errored completion and saturates at 255. If ERRCNT itself is written in an errorless transfer, the clear wins; a simultaneous increment cannot occur because that transfer is errorless.

## Timing
- Reset (asynchronous, immediate): state IDLE, `wcnt`=0, registers 0..14 = 0, `pready`=0, `pslverr`=0, `prdata`=0.
- Cycle numbering: setup cycle is T0, first access cycle is T1.
  - `pready` rises in cycle T1+`WAIT_STATES`. With `WAIT_STATES`=0, `pready`=1 in T1.
  - `pready`, `prdata` and `pslverr` are decoded from registered state and the current `psel`/`penable`; there is no extra register stage.
- Write data becomes readable in the next transfer's completion cycle.
- Back-to-back: the slave is in IDLE on the edge after completion, so it accepts an immediate setup cycle (the master's access→setup path) with no bubble.
- Reset asserted mid-ACCESS: transfer discarded, no register or ERRCNT change.
- Inputs other than `psel`/`penable` that change during ACCESS are ignored; captured values are used.

## Test plan
- Reset, then read all 16 indices with `WAIT_STATES`=1 → 0 for indices 0..14, `32'hA9B0_0001` for 15. `pready` is high in T2 of each transfer, and `pslverr`=0.
- Write `32'hDEADBEEF` to index 5 with `pstrb`=4'b0101, then read index 5 → `32'h00AD00EF`. Write with `pstrb`=0 → value unchanged.
- Write index 2 with `pprot`=3'b000 → `pslverr`=1, register stays 0, ERRCNT=1. Repeat with `pprot`=3'b001 → write succeeds, `pslverr`=0.
- Send misaligned address `32'h0000_0006`, out-of-range address `32'h0000_0040`, and a write to index 15 → each returns `pslverr`=1 with `prdata`=0. ERRCNT reaches 3, and saturates at 255 after 300 errors. Any write to index 14 → reads 0.
- `WAIT_STATES`=3 with back-to-back write then read to index 7 → `pready` is high in T4 only, and the read returns the written data with no idle cycle between transfers.
- Assert `preset` during T1 of a write to index 9, and separately drop `psel` in T1 → index 9 unchanged, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/apb_regfile_slave.sv
// APB4 completer with a 16-entry register bank: 14 general registers, a
// saturating error counter (index 14) and a read-only ID (index 15).
// Programmable wait states, byte strobes, privilege checks and pslverr.
module apb_regfile_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRIV_REGS   = 4,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [2:0]  pprot,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        pready
);

  typedef enum logic {StIdle, StAccess} state_t;

  state_t      state;
  logic [3:0]  wcnt;
  logic [29:0] cap_addr;
  logic        cap_write;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_strb;
  logic        cap_priv;

  logic [31:0] regs [14];
  logic [7:0]  errcnt;

  logic [3:0]  idx;
  logic        err;
  logic        complete;
  logic [31:0] rsel;

  // Address bits [31:30] are decoded upstream; pprot[2:1] carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{paddr[31:30], pprot[2:1]};

  assign idx = cap_addr[5:2];

  // Error decode works on the captured request, so late input changes are ignored.
  always_comb begin
    err = 1'b0;
    if (cap_addr[1:0] != 2'b00) err = 1'b1;
    if (cap_addr[29:6] != 24'd0) err = 1'b1;
    if (cap_write && idx == 4'd15) err = 1'b1;
    if (cap_write && (32'(idx) < PRIV_REGS) && !cap_priv) err = 1'b1;
  end

  // Read mux over the register map.
  always_comb begin
    rsel = 32'd0;
    if (idx == 4'd15) begin
      rsel = ID_VALUE;
    end else if (idx == 4'd14) begin
      rsel = {24'd0, errcnt};
    end else begin
      rsel = regs[idx];
    end
  end

  // Completion is decoded from registered state and live psel/penable, no extra stage.
  always_comb begin
    complete = (state == StAccess) && psel && penable && (wcnt == 4'd0);
    pready   = complete;
    pslverr  = complete && err;
    prdata   = (complete && !err && !cap_write) ? rsel : 32'd0;
  end

  // Transfer FSM: capture in setup, count wait states, return to idle on completion or abort.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= StIdle;
      wcnt      <= 4'd0;
      cap_addr  <= 30'd0;
      cap_write <= 1'b0;
      cap_wdata <= 32'd0;
      cap_strb  <= 4'd0;
      cap_priv  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (psel && !penable) begin
            cap_addr  <= paddr[29:0];
            cap_write <= pwrite;
            cap_wdata <= pwdata;
            cap_strb  <= pstrb;
            cap_priv  <= pprot[0];
            wcnt      <= 4'(WAIT_STATES);
            state     <= StAccess;
          end
        end
        StAccess: begin
          if (!psel) begin
            state <= StIdle;
          end else if (penable) begin
            if (wcnt != 4'd0) begin
              wcnt <= wcnt - 4'd1;
            end else begin
              state <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // General registers: byte-strobed commit at the closing edge of an errorless write.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int r = 0; r < 14; r++) begin
        regs[r] <= 32'd0;
      end
    end else if (complete && !err && cap_write && idx < 4'd14) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_strb[i]) begin
          regs[idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

  // Error counter: saturating increment on errored completions, cleared by any accepted write.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      errcnt <= 8'd0;
    end else if (complete) begin
      if (err) begin
        if (errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
      end else if (cap_write && idx == 4'd14) begin
        errcnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomized and directed bench for apb_regfile_slave. Two instances share
// the bus: dut0 with 1 wait state and dut1 with 3 wait states.
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;
  localparam int unsigned PRIV = 4;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel0 = 1'b0;
  logic        psel1 = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [2:0]  pprot = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata0, prdata1;
  logic        pslverr0, pslverr1, pready0, pready1;

  int checks = 0;
  int passes = 0;

  // Reference model: register contents and error counter per instance.
  logic [31:0] mreg [2][14];
  logic [7:0]  merr [2];

  always #5 pclk = ~pclk;

  apb_regfile_slave u_dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pslverr(pslverr0), .pready(pready0)
  );

  apb_regfile_slave #(.WAIT_STATES(3)) u_dut1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata1), .pslverr(pslverr1), .pready(pready1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passes++;
  endtask

  function automatic logic [33:0] outs(input int d);
    return (d == 0) ? {pready0, pslverr0, prdata0} : {pready1, pslverr1, prdata1};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 14; r++) mreg[d][r] = '0;
      merr[d] = '0;
    end
  endtask

  task automatic check_quiet(input string tag, input int d);
    logic [33:0] o;
    o = outs(d);
    check_eq({tag, "_pready"}, 32'(o[33]), 32'd0);
    check_eq({tag, "_pslverr"}, 32'(o[32]), 32'd0);
    check_eq({tag, "_prdata"}, o[31:0], 32'd0);
  endtask

  // One complete transfer on instance d, checked against the model; returns prdata.
  task automatic xfer(input int d, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] prot,
                      output logic [31:0] rd);
    int ws, idx, k;
    logic exp_err, done;
    logic [31:0] exp_rd;
    logic [33:0] o;
    ws  = (d == 0) ? 1 : 3;
    idx = int'(addr[5:2]);
    exp_err = (addr[1:0] != 0) || (addr[29:6] != 0) || (wr && idx == 15) ||
              (wr && idx < PRIV && !prot[0]);
    if (exp_err)       exp_rd = '0;
    else if (idx == 15) exp_rd = ID;
    else if (idx == 14) exp_rd = {24'd0, merr[d]};
    else               exp_rd = mreg[d][idx];
    rd = '0;
    if (d == 0) psel0 = 1'b1; else psel1 = 1'b1;
    penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = prot;
    @(negedge pclk);
    o = outs(d);
    check_eq("pready_setup", 32'(o[33]), 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    // Captured values must be used; scramble the live bus.
    paddr = $urandom; pwrite = ~wr; pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
    k = 1; done = 1'b0;
    while (!done && k <= 20) begin
      @(negedge pclk);
      o = outs(d);
      if (o[33]) begin
        check_eq("ready_cycle", 32'(k), 32'(ws + 1));
        check_eq("pslverr", 32'(o[32]), 32'(exp_err));
        if (!wr) check_eq("prdata", o[31:0], exp_rd);
        rd = o[31:0];
        done = 1'b1;
      end
      @(posedge pclk); #1;
      k++;
    end
    if (!done) check_eq("timeout", 32'd0, 32'd1);
    if (exp_err) begin
      if (merr[d] != 8'hFF) merr[d] = merr[d] + 8'd1;
    end else if (wr) begin
      if (idx == 14) merr[d] = '0;
      else if (idx < 14) begin
        for (int i = 0; i < 4; i++) if (st[i]) mreg[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
    end
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int r;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    check_quiet("reset", 0);
    check_quiet("reset1", 1);
    preset = 1'b0;
    @(posedge pclk); #1;

    // Reset contents of all 16 indices.
    for (int i = 0; i < 16; i++) begin
      xfer(0, 32'(i) << 2, 1'b0, '0, '0, 3'b000, rd);
      check_eq("reset_read", rd, (i == 15) ? ID : 32'd0);
    end

    // Byte strobes.
    xfer(0, 32'h14, 1'b1, 32'hDEADBEEF, 4'b0101, 3'b001, rd);
    xfer(0, 32'h14, 1'b0, '0, '0, 3'b000, rd);
    check_eq("strb_0101", rd, 32'h00AD00EF);
    xfer(0, 32'h14, 1'b1, 32'h12345678, 4'b0000, 3'b001, rd);
    xfer(0, 32'h14, 1'b0, '0, '0, 3'b000, rd);
    check_eq("strb_none", rd, 32'h00AD00EF);

    // Privilege.
    xfer(0, 32'h08, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, rd);
    xfer(0, 32'h08, 1'b0, '0, '0, 3'b000, rd);
    check_eq("unpriv_wr", rd, 32'd0);
    xfer(0, 32'h38, 1'b0, '0, '0, 3'b000, rd);
    check_eq("errcnt_1", rd, 32'd1);
    xfer(0, 32'h08, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, rd);
    xfer(0, 32'h08, 1'b0, '0, '0, 3'b000, rd);
    check_eq("priv_wr", rd, 32'hCAFEF00D);

    // Error sources and counter.
    xfer(0, 32'h38, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, rd);
    xfer(0, 32'h0000_0006, 1'b0, '0, '0, 3'b001, rd);
    xfer(0, 32'h0000_0040, 1'b0, '0, '0, 3'b001, rd);
    xfer(0, 32'h3C, 1'b1, 32'h1, 4'hF, 3'b001, rd);
    xfer(0, 32'h38, 1'b0, '0, '0, 3'b000, rd);
    check_eq("errcnt_3", rd, 32'd3);
    for (int i = 0; i < 300; i++) xfer(0, 32'h0000_0001, 1'b0, '0, '0, 3'b000, rd);
    xfer(0, 32'h38, 1'b0, '0, '0, 3'b000, rd);
    check_eq("errcnt_sat", rd, 32'd255);
    xfer(0, 32'h38, 1'b1, 32'h0, 4'h0, 3'b000, rd);
    xfer(0, 32'h38, 1'b0, '0, '0, 3'b000, rd);
    check_eq("errcnt_clr", rd, 32'd0);

    // Three wait states, back-to-back write then read.
    xfer(1, 32'h1C, 1'b1, 32'h7777_ABCD, 4'hF, 3'b000, rd);
    xfer(1, 32'h1C, 1'b0, '0, '0, 3'b000, rd);
    check_eq("ws3_b2b", rd, 32'h7777_ABCD);

    // Protocol abort in T1.
    xfer(0, 32'h24, 1'b1, 32'h0000_9999, 4'hF, 3'b000, rd);
    psel0 = 1'b1; penable = 1'b0; paddr = 32'h24; pwrite = 1'b1;
    pwdata = 32'hBAD0_BAD0; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    psel0 = 1'b0;
    @(negedge pclk);
    check_quiet("abort", 0);
    @(posedge pclk); #1;
    check_quiet("abort_idle", 0);
    xfer(0, 32'h24, 1'b0, '0, '0, 3'b000, rd);
    check_eq("abort_keep", rd, 32'h0000_9999);

    // Reset in T1 of a write.
    psel0 = 1'b1; penable = 1'b0; paddr = 32'h24; pwrite = 1'b1;
    pwdata = 32'h5555_AAAA; pstrb = 4'hF; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 preset = 1'b1;
    #1 check_quiet("rst_mid", 0);
    model_reset();
    psel0 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    check_quiet("rst_idle", 0);
    xfer(0, 32'h24, 1'b0, '0, '0, 3'b000, rd);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = {2'($urandom), 24'd0, 4'($urandom), 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a[29:6] = 24'($urandom_range(1, 255));
      xfer((n % 5 == 4) ? 1 : 0, a, 1'($urandom), $urandom, 4'($urandom),
           3'($urandom), rd);
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) xfer(d, 32'(i) << 2, 1'b0, '0, '0, 3'b000, rd);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
